run_controller: RTL and testbench

//  Host-side run sequencer placed directly upstream of the CPU core.
//  - Accepts a host Go request and a program number.
//  - Drives the core's Start input and program-bank select.
//  - Masks stale Ack, then counts execution cycles until the core raises Ack.
//  - Reports completion and cycle count back to the host/bench.

---
 rtl/run_controller.sv | 134 +++++++++++++
 tb/tb_run_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// ============================================================================
// Module   : run_controller
// Brief    : Host-side run sequencer feeding a CPU core's Start/program select
//            and timing each run. Optional watchdog: RUNCTRL_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module run_controller #(
    parameter int              START_W  = 2,
    parameter int              CNT_W    = 16,
    parameter int              NUM_PROG = 3,
    parameter int              PW       = 2,
    parameter logic [CNT_W-1:0] TIMEOUT = 16'hF000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic [PW-1:0]    ProgIdx,
    input  logic             CpuAck,
    output logic             CpuStart,
    output logic [PW-1:0]    ProgSel,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCt,
    output logic             TimedOut
);

`ifdef RUNCTRL_TIMEOUT_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    localparam int SCW = (START_W > 1) ? $clog2(START_W) : 1;
    localparam logic [SCW-1:0] START_LAST = SCW'(START_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_MASK  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [SCW-1:0]   start_cnt_q, start_cnt_d;
    logic [PW-1:0]    prog_sel_q, prog_sel_d;
    logic [CNT_W-1:0] cycle_ct_q, cycle_ct_d;
    logic             timed_out_q, timed_out_d;
    logic             done_q, done_d;
    logic             cpu_start_q, cpu_start_d;
    logic             busy_q, busy_d;
    logic             idx_ok;

    assign idx_ok = int'(ProgIdx) < NUM_PROG;

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        prog_sel_d  = prog_sel_q;
        cycle_ct_d  = cycle_ct_q;
        timed_out_d = timed_out_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Go && idx_ok) begin
                    state_d     = S_START;
                    start_cnt_d = START_LAST;
                    prog_sel_d  = ProgIdx;
                    cycle_ct_d  = '0;
                    timed_out_d = 1'b0;
                end
            end
            S_START: begin
                if (start_cnt_q == '0) begin
                    state_d = S_MASK;
                end else begin
                    start_cnt_d = start_cnt_q - 1'b1;
                end
            end
            // Any Ack seen here is left over from the previous program's halt.
            S_MASK: state_d = S_RUN;
            S_RUN: begin
                if (CpuAck) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (WDOG_EN && (cycle_ct_q == TIMEOUT - 1'b1)) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    cycle_ct_d  = TIMEOUT;
                    timed_out_d = 1'b1;
                end else if (!(&cycle_ct_q)) begin
                    cycle_ct_d = cycle_ct_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cpu_start_d = (state_d == S_START);
        busy_d      = (state_d == S_START) || (state_d == S_MASK) || (state_d == S_RUN);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            start_cnt_q <= '0;
            prog_sel_q  <= '0;
            cycle_ct_q  <= '0;
            timed_out_q <= 1'b0;
            done_q      <= 1'b0;
            cpu_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            prog_sel_q  <= prog_sel_d;
            cycle_ct_q  <= cycle_ct_d;
            timed_out_q <= timed_out_d;
            done_q      <= done_d;
            cpu_start_q <= cpu_start_d;
            busy_q      <= busy_d;
        end
    end

    assign CpuStart = cpu_start_q;
    assign ProgSel  = prog_sel_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign CycleCt  = cycle_ct_q;
    assign TimedOut = timed_out_q;

endmodule

`default_nettype wire

// File: tb/tb_run_controller.sv
// ============================================================================
// Module   : tb_run_controller
// Brief    : Directed bench for run_controller (16-bit and 4-bit counter builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_run_controller;

    localparam int START_W = 2;

`ifdef RUNCTRL_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset, Go, CpuAck;
    logic [1:0] ProgIdx;

    logic        CpuStart, Busy, Done, TimedOut;
    logic [1:0]  ProgSel;
    logic [15:0] CycleCt;
    logic        b_CpuStart, b_Busy, b_Done, b_TimedOut;
    logic [1:0]  b_ProgSel;
    logic [3:0]  b_CycleCt;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    run_controller #(.START_W(START_W), .CNT_W(16), .NUM_PROG(3), .PW(2)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .ProgIdx(ProgIdx), .CpuAck(CpuAck),
        .CpuStart(CpuStart), .ProgSel(ProgSel), .Busy(Busy), .Done(Done),
        .CycleCt(CycleCt), .TimedOut(TimedOut)
    );

    run_controller #(.START_W(START_W), .CNT_W(4), .NUM_PROG(3), .PW(2), .TIMEOUT(4'd10)) dut_b (
        .Clk(Clk), .Reset(Reset), .Go(Go), .ProgIdx(ProgIdx), .CpuAck(CpuAck),
        .CpuStart(b_CpuStart), .ProgSel(b_ProgSel), .Busy(b_Busy), .Done(b_Done),
        .CycleCt(b_CycleCt), .TimedOut(b_TimedOut)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is tracked by its age in cycles since launch plus the count.
    int m_busy[2], m_age[2], m_ct[2], m_to[2], m_sel[2], m_done[2];
    int cmax[2] = '{65535, 15};
    int tlim[2] = '{32'hF000, 10};

    always @(posedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                m_busy[k] = 0; m_age[k] = 0; m_ct[k] = 0;
                m_to[k] = 0; m_sel[k] = 0; m_done[k] = 0;
            end else begin
                m_done[k] = 0;
                if (m_busy[k] == 0) begin
                    if (Go && int'(ProgIdx) < 3) begin
                        m_busy[k] = 1; m_age[k] = 1; m_sel[k] = int'(ProgIdx);
                        m_ct[k] = 0; m_to[k] = 0;
                    end
                end else if (m_age[k] <= START_W + 1) begin
                    m_age[k]++;
                end else if (CpuAck) begin
                    m_busy[k] = 0; m_done[k] = 1;
                end else if (WD && m_ct[k] == tlim[k] - 1) begin
                    m_ct[k] = tlim[k]; m_to[k] = 1; m_busy[k] = 0; m_done[k] = 1;
                end else if (m_ct[k] < cmax[k]) begin
                    m_ct[k]++;
                end
            end
        end
    end

    function automatic logic [31:0] model_vec(input int k);
        logic st;
        st = (m_busy[k] != 0) && (m_age[k] <= START_W);
        return {st, m_sel[k][1:0], m_busy[k][0], m_done[k][0], m_to[k][0], m_ct[k][15:0]};
    endfunction

    always @(posedge Clk) begin
        #1;
        chk("cycle_main", {CpuStart, ProgSel, Busy, Done, TimedOut, CycleCt}, model_vec(0));
        chk("cycle_cnt4", {b_CpuStart, b_ProgSel, b_Busy, b_Done, b_TimedOut, 12'd0, b_CycleCt},
            model_vec(1));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    int starts;

    initial begin
        Reset = 1'b1; Go = 1'b0; ProgIdx = 2'd0; CpuAck = 1'b0;
        cyc(2);
        chk("reset_main", {CpuStart, ProgSel, Busy, Done, TimedOut, CycleCt}, 32'd0);
        chk("reset_cnt4", {b_CpuStart, b_ProgSel, b_Busy, b_Done, b_TimedOut, b_CycleCt}, 32'd0);
        Reset = 1'b0;

        // Basic run: Ack after 20 counted RUN cycles
        Go = 1'b1; ProgIdx = 2'd1; cyc(1); Go = 1'b0;
        starts = 0;
        for (int i = 0; i < 23; i++) begin
            starts += int'(CpuStart);
            cyc(1);
        end
        chk("t1_ct_before_ack", 32'(CycleCt), 32'd20);
        CpuAck = 1'b1; cyc(1);
        chk("t1_done", 32'(Done), 32'd1);
        chk("t1_ct", 32'(CycleCt), 32'd20);
        chk("t1_sel", 32'(ProgSel), 32'd1);
        chk("t1_busy", 32'(Busy), 32'd0);
        chk("t1_start_len", 32'(starts), 32'd2);
        CpuAck = 1'b0; cyc(1);
        chk("t1_done_pulse", 32'(Done), 32'd0);

        // Stale Ack held through reset and launch
        Reset = 1'b1; CpuAck = 1'b1; cyc(2);
        Reset = 1'b0; Go = 1'b1; ProgIdx = 2'd2; cyc(1); Go = 1'b0;
        cyc(3);
        chk("t2_run_busy", {31'd0, Busy}, 32'd1);
        chk("t2_run_nodone", 32'(Done), 32'd0);
        cyc(1);
        chk("t2_done", 32'(Done), 32'd1);
        chk("t2_ct", 32'(CycleCt), 32'd0);
        // Go in the Done-pulse cycle is accepted
        Go = 1'b1; ProgIdx = 2'd2; CpuAck = 1'b0; cyc(1); Go = 1'b0;
        chk("t2_go_in_done", 32'(CpuStart), 32'd1);

        // Go during RUN and out-of-range ProgIdx are ignored
        cyc(5);
        Go = 1'b1; ProgIdx = 2'd1; cyc(1);
        ProgIdx = 2'd3; cyc(1); Go = 1'b0; cyc(1);
        chk("t3_sel_held", 32'(ProgSel), 32'd2);
        chk("t3_busy", 32'(Busy), 32'd1);
        chk("t3_nostart", 32'(CpuStart), 32'd0);
        CpuAck = 1'b1; cyc(1);
        chk("t3_done", 32'(Done), 32'd1);
        CpuAck = 1'b0; Go = 1'b1; ProgIdx = 2'd3; cyc(1); Go = 1'b0;
        chk("t3_bad_idx", {CpuStart, Busy, ProgSel}, 32'd2);

        // Reset mid-run at CycleCt=7
        Go = 1'b1; ProgIdx = 2'd1; cyc(1); Go = 1'b0;
        cyc(10);
        chk("t4_ct7", 32'(CycleCt), 32'd7);
        Reset = 1'b1; cyc(1);
        chk("t4_reset", {CpuStart, ProgSel, Busy, Done, TimedOut, CycleCt}, 32'd0);
        Reset = 1'b0;

        // Ack never rises: 4-bit counter saturates (or watchdog fires)
        Go = 1'b1; ProgIdx = 2'd0; cyc(1); Go = 1'b0;
        cyc(29);
        chk("t5_main_ct", 32'(CycleCt), 32'd26);
`ifdef RUNCTRL_TIMEOUT_EN
        chk("t5_b_ct", 32'(b_CycleCt), 32'd10);
        chk("t5_b_to", 32'(b_TimedOut), 32'd1);
        chk("t5_b_busy", 32'(b_Busy), 32'd0);
`else
        chk("t5_b_ct", 32'(b_CycleCt), 32'd15);
        chk("t5_b_to", 32'(b_TimedOut), 32'd0);
        chk("t5_b_busy", 32'(b_Busy), 32'd1);
`endif
        Reset = 1'b1; cyc(1); Reset = 1'b0;

        // Ack arriving on the watchdog's last cycle wins
        Go = 1'b1; ProgIdx = 2'd2; cyc(1); Go = 1'b0;
        cyc(12);
        chk("t6_b_ct9", 32'(b_CycleCt), 32'd9);
        CpuAck = 1'b1; cyc(1);
        chk("t6_b_done", 32'(b_Done), 32'd1);
        chk("t6_b_to", 32'(b_TimedOut), 32'd0);
        chk("t6_b_ct", 32'(b_CycleCt), 32'd9);
        CpuAck = 1'b0; cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
